// File: rtl/rx_stream_mux.sv
// rtl/rx_stream_mux.sv - RX FIFO to FT601 burst multiplexer with header framing
module rx_stream_mux #(
  parameter int          MAX_BURST = 16,
  parameter logic [15:0] SYNC_WORD = 16'hA55A
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   grant,
  input  logic         grant_valid,
  input  logic [7:0]   fifo_empty,
  input  logic [7:0]   fifo_almost_empty,
  input  logic [255:0] fifo_rd_data,
  output logic [7:0]   fifo_rd_en,
  output logic [31:0]  out_data,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready,
  output logic         busy,
  output logic         burst_done
);

  typedef enum logic [1:0] {IDLE, HEADER, DATA, DONE} state_t;

  localparam logic [7:0] LAST_IDX = 8'(MAX_BURST - 1);

  state_t      state;
  logic [2:0]  sel;
  logic [7:0]  count;

  logic        can_load;
  logic        sel_empty;
  logic        sel_almost;
  logic [31:0] sel_data;
  logic        data_load;
  logic        data_last;

  // Output register may take a new word when it is empty or being drained this cycle;
  // the pop strobe fires in the same cycle a payload word is captured (FWFT FIFOs).
  always_comb begin
    can_load   = !out_valid || out_ready;
    sel_empty  = fifo_empty[sel];
    sel_almost = fifo_almost_empty[sel];
    sel_data   = fifo_rd_data[{sel, 5'd0} +: 32];
    data_load  = (state == DATA) && can_load && !sel_empty;
    data_last  = (count == LAST_IDX) || sel_almost;
    fifo_rd_en = '0;
    if (data_load && !rst) begin
      fifo_rd_en = 8'b1 << sel;
    end
  end

  // Burst sequencer: owns the output register, word count, busy and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= '0;
      count      <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      if (burst_done) begin
        busy <= 1'b0;
      end
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (grant_valid && !fifo_empty[grant]) begin
            sel   <= grant;
            count <= '0;
            busy  <= 1'b1;
            state <= HEADER;
          end
        end
        HEADER: begin
          if (can_load) begin
            out_data  <= {SYNC_WORD, 13'd0, sel};
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (data_load) begin
            out_data  <= sel_data;
            out_valid <= 1'b1;
            out_last  <= data_last;
            count     <= count + 8'd1;
            if (data_last) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            burst_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_stream_mux.sv
// tb/tb_rx_stream_mux.sv - scoreboard bench for rx_stream_mux
module tb_rx_stream_mux;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   grant;
  logic         grant_valid;
  logic [7:0]   fifo_empty;
  logic [7:0]   fifo_almost_empty;
  logic [255:0] fifo_rd_data;
  logic [7:0]   fifo_rd_en;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_last;
  logic         out_ready;
  logic         busy;
  logic         burst_done;

  int tests = 0;
  int fails = 0;

  logic [31:0] fmem [8][64];
  int          wr_ptr [8];
  int          rd_ptr [8];
  int          pops [8];
  logic [32:0] exp_q [$];
  int          done_cnt = 0;
  logic        busy_seen = 1'b0;

  rx_stream_mux #(.MAX_BURST(16), .SYNC_WORD(16'hA55A)) dut (
    .clk(clk), .rst(rst), .grant(grant), .grant_valid(grant_valid),
    .fifo_empty(fifo_empty), .fifo_almost_empty(fifo_almost_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .burst_done(burst_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pword(input int p, input int k);
    return {4'h0, 4'(p), 16'h0000, 8'(k)};
  endfunction

  function automatic int total_pops();
    int s = 0;
    for (int i = 0; i < 8; i++) s += pops[i];
    return s;
  endfunction

  task automatic fill(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      fmem[p][wr_ptr[p]] = pword(p, wr_ptr[p]);
      wr_ptr[p]++;
    end
  endtask

  task automatic push_burst(input logic [31:0] hdr, input int p, input int k0, input int n);
    exp_q.push_back({1'b0, hdr});
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), pword(p, k0 + i)});
  endtask

  task automatic do_grant(input logic [2:0] g);
    @(negedge clk);
    grant = g;
    grant_valid = 1'b1;
    @(negedge clk);
    grant_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < 300) begin
      @(negedge clk);
      #4;
      n++;
    end
    check({name, "_done_seen"}, (done_cnt == d0 + 1), 1);
    repeat (3) @(negedge clk);
    check({name, "_done_once"}, done_cnt, d0 + 1);
    check({name, "_all_words"}, exp_q.size(), 0);
  endtask

  // FIFO models: sample the pop strobe late in the cycle, apply it just after the edge.
  always begin
    logic [7:0] en_s;
    @(negedge clk);
    #3;
    en_s = fifo_rd_en;
    @(posedge clk);
    #1;
    for (int p = 0; p < 8; p++) begin
      if (en_s[p]) begin
        if (rd_ptr[p] == wr_ptr[p]) begin
          fails++;
          $display("FAIL pop_empty: peripheral %0d popped while empty", p);
        end else begin
          rd_ptr[p]++;
          pops[p]++;
        end
      end
    end
    for (int p = 0; p < 8; p++) begin
      fifo_empty[p]        = (wr_ptr[p] - rd_ptr[p]) == 0;
      fifo_almost_empty[p] = (wr_ptr[p] - rd_ptr[p]) == 1;
      fifo_rd_data[p*32 +: 32] = (rd_ptr[p] < 64) ? fmem[p][rd_ptr[p] % 64] : 32'hDEAD0000;
    end
  end

  // Monitor: scoreboard compare on handshake, stall stability, strobe shape.
  always begin
    logic        prev_stalled;
    logic [33:0] prev_word;
    logic [32:0] e;
    prev_stalled = 1'b0;
    prev_word    = '0;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        prev_stalled = 1'b0;
      end else begin
        if (fifo_rd_en != 8'd0) check("rd_en_onehot", $countones(fifo_rd_en), 1);
        if (prev_stalled) check("stall_hold", {out_valid, out_last, out_data}, prev_word);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_word: got %h last %b, expected none", out_data, out_last);
          end else begin
            e = exp_q.pop_front();
            check("word", {out_last, out_data}, e);
          end
        end
        prev_stalled = out_valid && !out_ready;
        prev_word    = {out_valid, out_last, out_data};
        if (burst_done) done_cnt++;
        if (busy) busy_seen = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    for (int p = 0; p < 8; p++) begin
      wr_ptr[p] = 0;
      rd_ptr[p] = 0;
      pops[p]   = 0;
    end
    fifo_empty        = 8'hFF;
    fifo_almost_empty = 8'h00;
    fifo_rd_data      = '0;
    rst = 1'b1;
    grant = 3'd0;
    grant_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    check("reset_outputs", {fifo_rd_en, out_data, out_valid, out_last, busy, burst_done}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Long FIFO: burst capped at 16 words, header/first-valid latency.
    fill(3, 40);
    push_burst(32'hA55A0003, 3, 0, 16);
    repeat (2) @(negedge clk);
    grant = 3'd3;
    grant_valid = 1'b1;
    @(negedge clk);
    grant_valid = 1'b0;
    #3;
    check("lat_busy", busy, 1);
    check("lat_no_valid_yet", out_valid, 0);
    @(negedge clk);
    #3;
    check("lat_header_valid", out_valid, 1);
    check("lat_header_data", out_data, 32'hA55A0003);
    wait_done("b3");
    check("b3_pops", pops[3], 16);
    check("b3_other_pops", total_pops() - pops[3], 0);
    check("b3_idle_busy", busy, 0);

    // Short FIFO: almost_empty terminates the burst.
    fill(5, 3);
    push_burst(32'hA55A0005, 5, 0, 3);
    @(negedge clk);
    do_grant(3'd5);
    wait_done("b5");
    check("b5_pops", pops[5], 3);

    // Backpressure toggling over a 10-word burst.
    fill(0, 10);
    push_burst(32'hA55A0000, 0, 0, 10);
    @(negedge clk);
    do_grant(3'd0);
    begin
      int d0 = done_cnt;
      int n = 0;
      while (done_cnt == d0 && n < 200) begin
        @(negedge clk);
        out_ready = ~out_ready;
        n++;
      end
    end
    out_ready = 1'b1;
    wait_done("b0");
    check("b0_pops", pops[0], 10);

    // Grant to an empty FIFO is ignored.
    snap = total_pops();
    busy_seen = 1'b0;
    do_grant(3'd2);
    repeat (6) @(negedge clk);
    check("empty_grant_busy", busy_seen, 0);
    check("empty_grant_pops", total_pops(), snap);
    check("empty_grant_done", burst_done, 0);

    // Grant changes mid-burst are ignored.
    fill(1, 8);
    fill(6, 4);
    push_burst(32'hA55A0001, 1, 0, 8);
    @(negedge clk);
    do_grant(3'd1);
    grant = 3'd6;
    grant_valid = 1'b1;
    repeat (4) @(negedge clk);
    grant_valid = 1'b0;
    wait_done("b1");
    check("b1_pops", pops[1], 8);
    check("b1_no_pop6", pops[6], 0);

    // Reset after the 5th payload word is accepted.
    fill(4, 20);
    push_burst(32'hA55A0004, 4, 0, 5);
    exp_q[5][32] = 1'b0;
    @(negedge clk);
    do_grant(3'd4);
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("rst_reached_5th", exp_q.size(), 0);
    end
    rst = 1'b1;
    snap = total_pops();
    @(negedge clk);
    #3;
    check("rst_outputs", {fifo_rd_en, out_data, out_valid, out_last, busy, burst_done}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_no_pops", total_pops(), snap);
    check("rst_pops4", pops[4], 6);
    push_burst(32'hA55A0004, 4, 6, 14);
    do_grant(3'd4);
    wait_done("b4r");
    check("b4r_pops", pops[4], 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rx_stream_mux.md
RX_STREAM_MUX -- requirements
Module: rx_stream_mux

Interface
REQ-001 Parameter MAX_BURST, default 16, maximum payload words per burst, legal range 1..255.
REQ-002 Parameter SYNC_WORD, default 16'hA55A, upper half of every header word.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 grant  input  3  peripheral index chosen by the arbiter.
REQ-006 grant_valid  input  1  arbiter request to start a burst from grant.
REQ-007 fifo_empty  input  8  per-peripheral RX FIFO empty flag.
REQ-008 fifo_almost_empty  input  8  per-peripheral flag, exactly one word left.
REQ-009 fifo_rd_data  input  256  first-word-fall-through data; peripheral i on bits [32i+31:32i].
REQ-010 fifo_rd_en  output  8  one-hot pop strobe to peripheral RX FIFOs.
REQ-011 out_data  output  32  word to FT601 controller.
REQ-012 out_valid  output  1  out_data valid.
REQ-013 out_last  output  1  marks final word of a burst.
REQ-014 out_ready  input  1  FT601 controller accepts word when high with out_valid.
REQ-015 busy  output  1  high from burst start until burst_done cycle inclusive.
REQ-016 burst_done  output  1  one-cycle pulse when last word of a burst is accepted.

Function
REQ-017 States SHALL be IDLE, HEADER, DATA, DONE.
REQ-018 IDLE: when grant_valid=1 and fifo_empty[grant]=0, grant SHALL be latched into sel and state SHALL go to HEADER next cycle; otherwise stay IDLE.
REQ-019 grant_valid with fifo_empty[grant]=1 SHALL be ignored (no header, no pop).
REQ-020 sel SHALL remain constant until IDLE; grant/grant_valid changes mid-burst ignored.
REQ-021 out_data/out_valid/out_last SHALL come from one output register; load allowed when out_valid=0 or (out_valid & out_ready).
REQ-022 HEADER: load {SYNC_WORD, 13'd0, sel} with out_last=0; first out_valid one cycle after grant_valid sampled; then DATA.
REQ-023 DATA: each load SHALL take fifo_rd_data of sel, pulse fifo_rd_en[sel] the same cycle, increment word count.
REQ-024 fifo_rd_en SHALL be one-hot or zero; never asserted outside DATA loads.
REQ-025 Word loaded with out_last=1 when count = MAX_BURST-1 or fifo_almost_empty[sel]=1; state then DONE.
REQ-026 DATA with fifo_empty[sel]=1 SHALL stall: no load, no pop, count held, out_valid falls once register drains.
REQ-027 DONE: wait for acceptance of the out_last word; that cycle pulse burst_done, go IDLE.
REQ-028 out_valid high with out_ready low SHALL hold out_data/out_last stable.
REQ-029 Back-to-back: with out_ready=1 constant, one word per cycle, no bubbles between header and data.
REQ-030 Count SHALL be 8 bits, cleared on entry to HEADER; payload per burst 1..MAX_BURST.

Reset
REQ-031 rst=1 SHALL force IDLE, sel=0, count=0, fifo_rd_en=0, out_data=0, out_valid=0, out_last=0, busy=0, burst_done=0 at next edge.
REQ-032 rst mid-burst SHALL abort without further pops; the un-accepted output word is discarded.
REQ-033 rst overrides grant_valid in the same cycle.

Verification
REQ-034 FIFO 3 holds 40 words, MAX_BURST=16, out_ready=1, grant=3 pulse -> header 32'hA55A0003, 16 payload words in order, out_last on 16th, burst_done once, 16 pops on fifo_rd_en[3] only.
REQ-035 FIFO 5 holds 3 words (almost_empty on third) -> header 32'hA55A0005, 3 words, out_last on third, burst length 4 words.
REQ-036 out_ready toggled 1/0 every cycle over 10-word burst -> words stable while stalled, no drop or duplicate, pops equal accepted payload words.
REQ-037 grant_valid with grant=2 and fifo_empty[2]=1 -> busy stays 0, no output, no pops.
REQ-038 rst asserted after 5th payload word accepted -> all outputs 0 next cycle, no further pops, new grant after reset starts fresh header.
REQ-039 grant changed to 6 mid-burst from peripheral 1 -> all payload from peripheral 1, fifo_rd_en[6] never pulses.
